// File: rtl/uart_alu_top.sv
// UART-driven 8-bit ALU: receives A, B and opcode bytes, returns the result byte.
// Build with ALU_SHIFT_EN defined to add the SRA/SRL opcodes.
module uart_alu_top #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clock,
  input  logic r_reset,
  input  logic rx_data,
  output logic tx_data
);

  localparam int DIV    = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int NB_DIV = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NB_OS  = $clog2(OVERSAMPLE);
  localparam int NB_BIT = $clog2(NB_DATA);

  localparam logic [NB_DIV-1:0] DIV_LAST = NB_DIV'(DIV - 1);
  localparam logic [NB_OS-1:0]  OS_LAST  = NB_OS'(OVERSAMPLE - 1);
  localparam logic [NB_OS-1:0]  OS_HALF  = NB_OS'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_BIT-1:0] BIT_LAST = NB_BIT'(NB_DATA - 1);

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
`ifdef ALU_SHIFT_EN
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
`endif

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
  typedef enum logic [2:0] {
    S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_SEND, S_WAIT_TX
  } if_st_t;

  logic [NB_DIV-1:0] bcnt_q, bcnt_d;
  logic              tick;

  logic [2:0]         sync_q;
  rx_st_t             rs_q, rs_d;
  logic [NB_OS-1:0]   rcnt_q, rcnt_d;
  logic [NB_BIT-1:0]  rbit_q, rbit_d;
  logic [NB_DATA-1:0] rsr_q, rsr_d;
  logic               rx_done;
  logic               rxs;

  tx_st_t             ts_q, ts_d;
  logic [NB_OS-1:0]   tcnt_q, tcnt_d;
  logic [NB_BIT-1:0]  tbit_q, tbit_d;
  logic [NB_DATA-1:0] tsr_q, tsr_d;
  logic               tx_done;
  logic               tx_start;

  if_st_t             is_q, is_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic [NB_OP-1:0]   op_q, op_d, alu_op;

  assign tick    = (bcnt_q == DIV_LAST);
  assign bcnt_d  = tick ? '0 : bcnt_q + 1'b1;
  assign rxs     = sync_q[1];
  assign alu_op  = rsr_q[NB_OP-1:0];
  assign tx_data = (ts_q == T_START) ? 1'b0 :
                   (ts_q == T_DATA)  ? tsr_q[0] : 1'b1;

  always_ff @(posedge i_clock) begin
    if (r_reset) begin
      bcnt_q <= '0;
      sync_q <= '1;
      rs_q   <= R_IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsr_q  <= '0;
      ts_q   <= T_IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsr_q  <= '0;
      is_q   <= S_WAIT_A;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      sync_q <= {sync_q[1:0], rx_data};
      rs_q   <= rs_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsr_q  <= rsr_d;
      ts_q   <= ts_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsr_q  <= tsr_d;
      is_q   <= is_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      res_q  <= res_d;
    end
  end

  // Start needs a true falling edge, so a low line after a framing error waits
  always_comb begin
    rs_d    = rs_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsr_d   = rsr_q;
    rx_done = 1'b0;
    unique case (rs_q)
      R_IDLE: if (sync_q[2] && !sync_q[1]) begin
        rs_d   = R_START;
        rcnt_d = '0;
      end
      R_START: if (tick) begin
        if (rcnt_q == OS_HALF) begin
          rcnt_d = '0;
          rbit_d = '0;
          rs_d   = rxs ? R_IDLE : R_DATA;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      R_DATA: if (tick) begin
        if (rcnt_q == OS_LAST) begin
          rcnt_d = '0;
          rsr_d  = {rxs, rsr_q[NB_DATA-1:1]};
          rbit_d = rbit_q + 1'b1;
          if (rbit_q == BIT_LAST) rs_d = R_STOP;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      R_STOP: if (tick) begin
        if (rcnt_q == OS_LAST) begin
          rcnt_d  = '0;
          rx_done = rxs;
          rs_d    = R_IDLE;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_comb begin
    ts_d    = ts_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tsr_d   = tsr_q;
    tx_done = 1'b0;
    unique case (ts_q)
      T_IDLE: if (tx_start) begin
        tsr_d  = res_q;
        tcnt_d = '0;
        ts_d   = T_START;
      end
      T_START: if (tick) begin
        if (tcnt_q == OS_LAST) begin
          tcnt_d = '0;
          tbit_d = '0;
          ts_d   = T_DATA;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      T_DATA: if (tick) begin
        if (tcnt_q == OS_LAST) begin
          tcnt_d = '0;
          tsr_d  = tsr_q >> 1;
          tbit_d = tbit_q + 1'b1;
          if (tbit_q == BIT_LAST) ts_d = T_STOP;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      T_STOP: if (tick) begin
        if (tcnt_q == OS_LAST) begin
          tcnt_d  = '0;
          tx_done = 1'b1;
          ts_d    = T_IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      default: ts_d = T_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD: alu_res = a_q + b_q;
      OP_SUB: alu_res = a_q - b_q;
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
`ifdef ALU_SHIFT_EN
      OP_SRA: alu_res = $unsigned($signed(a_q) >>> b_q[2:0]);
      OP_SRL: alu_res = a_q >> b_q[2:0];
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    is_d     = is_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    tx_start = 1'b0;
    unique case (is_q)
      S_WAIT_A: if (rx_done) begin
        a_d  = rsr_q;
        is_d = S_WAIT_B;
      end
      S_WAIT_B: if (rx_done) begin
        b_d  = rsr_q;
        is_d = S_WAIT_OP;
      end
      S_WAIT_OP: if (rx_done) begin
        op_d  = alu_op;
        res_d = alu_res;
        is_d  = S_SEND;
      end
      S_SEND: begin
        tx_start = 1'b1;
        is_d     = S_WAIT_TX;
      end
      S_WAIT_TX: if (tx_done) is_d = S_WAIT_A;
      default: is_d = S_WAIT_A;
    endcase
  end

endmodule

// File: tb/tb_uart_alu_top.sv
// Randomized scoreboard bench for uart_alu_top over the serial pins.
// Runs a fast baud setting; reply frames are decoded by an independent monitor.
module tb_uart_alu_top;

  localparam int CLK_HZ = 4_800_000;
  localparam int BAUD   = 100_000;
  localparam int OS     = 16;
  localparam int BIT    = OS * ((CLK_HZ + BAUD * OS / 2) / (BAUD * OS));

  logic i_clock = 1'b0;
  logic r_reset = 1'b1;
  logic rx_data = 1'b1;
  logic tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_alu_top #(
    .NB_DATA(8), .NB_OP(6), .CLK_HZ(CLK_HZ),
    .BAUD(BAUD), .OVERSAMPLE(OS)
  ) dut (
    .i_clock(i_clock),
    .r_reset(r_reset),
    .rx_data(rx_data),
    .tx_data(tx_data)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [7:0] model(int a, int b, int op);
    int o = op % 64;
    int s = b % 8;
    int r = 0;
    int sa, q;
    case (o)
      32: r = (a + b) % 256;
      34: r = (a - b + 256) % 256;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
`ifdef ALU_SHIFT_EN
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        q  = sa / (1 << s);
        if (sa < 0 && (sa % (1 << s)) != 0) q = q - 1;
        r  = q & 255;
      end
      2: r = a / (1 << s);
`endif
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    rx_data = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_data = v[i];
      idle(BIT);
    end
    rx_data = stop;
    idle(BIT);
    rx_data = 1'b1;
    idle(BIT / 4);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic wait_reply(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      idle(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no reply within %0d cycles, expected %h",
               name, n, exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic txn(input string name, input int a, input int b, input int op);
    exp_q.push_back(model(a, b, op));
    send_frame(8'(a), 1'b1);
    send_frame(8'(b), 1'b1);
    send_frame(8'(op), 1'b1);
    wait_reply(name);
  endtask

  // Reply decoder: samples mid-bit, compares with the scoreboard head
  initial begin
    logic [7:0] got, e;
    logic st, sp;
    forever begin
      @(negedge i_clock);
      if (!r_reset && tx_data === 1'b0) begin
        idle(BIT / 2);
        st = tx_data;
        for (int i = 0; i < 8; i++) begin
          idle(BIT);
          got[i] = tx_data;
        end
        idle(BIT);
        sp = tx_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got %h, expected no frame", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e || st !== 1'b0 || sp !== 1'b1) begin
            errors++;
            $display("FAIL reply: got %h (start %b stop %b), expected %h (start 0 stop 1)",
                     got, st, sp, e);
          end
        end
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    int ops[9];
    int a, b, op, k;
    ops = '{32, 34, 36, 37, 38, 39, 3, 2, 0};

    idle(2);
    check_bit("tx_in_reset", tx_data, 1'b1);
    idle(1);
    r_reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 4 * BIT; i++) begin
      idle(1);
      if (tx_data !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d low cycles, expected 0", lows);
    end

    txn("add", 22, 18, 'h20);
    txn("sub_wrap", 5, 9, 'h22);
    txn("xor", 'hF0, 'h3C, 'h26);
    txn("nor", 'h0F, 'hF0, 'h27);
    txn("sra", 'h80, 3, 'h03);
    txn("srl", 'h80, 3, 'h02);
    txn("unknown", 'h5A, 'h33, 'h3F);
    txn("and_hi_bits", 'hCA, 'h6F, 'hE4);

    rx_data = 1'b0;
    idle(BIT / 4);
    rx_data = 1'b1;
    idle(BIT);
    txn("after_glitch", 22, 18, 'h20);

    send_frame(8'h55, 1'b0);
    idle(BIT);
    txn("after_frame_err", 22, 18, 'h20);

    send_frame(8'd7, 1'b1);
    rx_data = 1'b0;
    idle(BIT);
    rx_data = 1'b1;
    idle(BIT);
    rx_data = 1'b0;
    idle(BIT / 2);
    r_reset = 1'b1;
    idle(2);
    rx_data = 1'b1;
    r_reset = 1'b0;
    idle(1);
    check_bit("tx_after_mid_reset", tx_data, 1'b1);
    idle(2 * BIT);
    txn("after_mid_reset", 1, 2, 'h20);

    for (int n = 0; n < 9; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      k = int'($urandom_range(0, 8));
      if (k == 8) op = int'($urandom_range(0, 255));
      else op = ops[k] + 64 * int'($urandom_range(0, 3));
      txn("random", a, b, op);
    end

    idle(2 * BIT);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
